// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the multi-cycle serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational W-bit subtract slice: d = a - b - bin (mod 2^W), bout = borrow out.
module sub_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] full_s;

  // One extra bit catches the borrow as the sign of the widened difference.
  always_comb begin
    full_s = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  end

  assign d    = full_s[W-1:0];
  assign bout = full_s[W];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle ripple subtractor, BITS_PER_CYCLE bits per clock, LSB slice first.
// Optional signed overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS       = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic                signed_ovf
`endif
);

  localparam int K  = NUM_BITS / BITS_PER_CYCLE;
  localparam int CW = cnt_width(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  sub_state_t                state_r, state_nxt_s;
  logic [CW-1:0]             count_r;
  logic [NUM_BITS-1:0]       a_sh_r, b_sh_r;
  logic                      borrow_r;
  logic [NUM_BITS-1:0]       diff_r;
  logic                      underflow_r;
  logic                      accept_s;
  logic                      last_s;
  logic [BITS_PER_CYCLE-1:0] slice_d_s;
  logic                      slice_bout_s;
  logic [NUM_BITS-1:0]       result_s;

  sub_slice #(.W(BITS_PER_CYCLE)) u_slice (
    .a    (a_sh_r[BITS_PER_CYCLE-1:0]),
    .b    (b_sh_r[BITS_PER_CYCLE-1:0]),
    .bin  (borrow_r),
    .d    (slice_d_s),
    .bout (slice_bout_s)
  );

  // Result bits enter from the top so the final slice lands the word in place.
  generate
    if (K > 1) begin : g_multi
      logic [NUM_BITS-BITS_PER_CYCLE-1:0] work_r;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          work_r <= '0;
        end else if (state_r == SUB) begin
          work_r <= result_s[NUM_BITS-1:BITS_PER_CYCLE];
        end else begin
          work_r <= work_r;
        end
      end

      assign result_s = {slice_d_s, work_r};
    end else begin : g_single
      assign result_s = slice_d_s;
    end
  endgenerate

  always_comb begin
    accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    last_s   = (state_r == SUB) && (count_r == LAST);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? SUB : IDLE;
      SUB:     state_nxt_s = (count_r == LAST) ? DONE : SUB;
      DONE:    state_nxt_s = start ? SUB : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_r == SUB);
    done = (state_r == DONE);
  end

  // Operand shift registers, running borrow and slice counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      borrow_r <= 1'b0;
      count_r  <= '0;
    end else if (accept_s) begin
      a_sh_r   <= a;
      b_sh_r   <= b;
      borrow_r <= borrow_in;
      count_r  <= '0;
    end else if (state_r == SUB) begin
      a_sh_r   <= a_sh_r >> BITS_PER_CYCLE;
      b_sh_r   <= b_sh_r >> BITS_PER_CYCLE;
      borrow_r <= slice_bout_s;
      count_r  <= count_r + CW'(1);
    end else begin
      a_sh_r   <= a_sh_r;
      b_sh_r   <= b_sh_r;
      borrow_r <= borrow_r;
      count_r  <= count_r;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      diff_r      <= '0;
      underflow_r <= 1'b0;
    end else if (last_s) begin
      diff_r      <= result_s;
      underflow_r <= slice_bout_s;
    end else begin
      diff_r      <= diff_r;
      underflow_r <= underflow_r;
    end
  end

  assign diff      = diff_r;
  assign underflow = underflow_r;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb_r, b_msb_r, signed_ovf_r;

  // Operand signs are kept aside because the shift registers lose them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_msb_r      <= 1'b0;
      b_msb_r      <= 1'b0;
      signed_ovf_r <= 1'b0;
    end else if (accept_s) begin
      a_msb_r      <= a[NUM_BITS-1];
      b_msb_r      <= b[NUM_BITS-1];
      signed_ovf_r <= signed_ovf_r;
    end else if (last_s) begin
      a_msb_r      <= a_msb_r;
      b_msb_r      <= b_msb_r;
      signed_ovf_r <= (a_msb_r != b_msb_r) && (result_s[NUM_BITS-1] != a_msb_r);
    end else begin
      a_msb_r      <= a_msb_r;
      b_msb_r      <= b_msb_r;
      signed_ovf_r <= signed_ovf_r;
    end
  end

  assign signed_ovf = signed_ovf_r;
`endif

endmodule
